// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter, 32-bit address / 16-bit data.
// Define WB_ARB_TIMEOUT_EN to build in the hung-slave watchdog.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        timeout_o,
  output logic [7:0]  to_count_o
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("wb_arbiter_2m: TIMEOUT must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
  } wb_req_t;

  state_t  state;
  state_t  state_nx;
  logic    last_grant;
  logic    last_grant_nx;
  wb_req_t req0;
  wb_req_t req1;
  wb_req_t req;
  logic    own0;
  logic    own1;
  logic    raw_stb;
  logic    to_fire;
  logic    ack_any;
  logic [15:0] rdata;

  assign req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                  adr: m0_adr_i, dat: m0_dat_i};
  assign req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                  adr: m1_adr_i, dat: m1_dat_i};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  // Tie in IDLE goes to the master that did not own the bus last.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant))
          state_nx = OWN0;
        else if (m1_cyc_i)
          state_nx = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i)
          state_nx = m1_cyc_i ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!m1_cyc_i)
          state_nx = m0_cyc_i ? OWN0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == OWN0)
      last_grant_nx = 1'b0;
    else if (state_nx == OWN1)
      last_grant_nx = 1'b1;
  end

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  always_comb begin
    req = '0;
    unique case (state)
      OWN0:    req = req0;
      OWN1:    req = req1;
      default: req = '0;
    endcase
  end

  assign raw_stb = req.cyc & req.stb;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic [7:0] wd_cnt;
  logic [7:0] to_count;

  // A real ack on the limit cycle beats the watchdog.
  assign to_fire = raw_stb & ~s_ack_i & (wd_cnt == TO_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt   <= '0;
      to_count <= '0;
    end else begin
      if (raw_stb && !s_ack_i && !to_fire)
        wd_cnt <= wd_cnt + 8'd1;
      else
        wd_cnt <= '0;
      if (to_fire && to_count != 8'hFF)
        to_count <= to_count + 8'd1;
    end
  end

  assign timeout_o  = to_fire;
  assign to_count_o = to_count;
`else
  assign to_fire    = 1'b0;
  assign timeout_o  = 1'b0;
  assign to_count_o = '0;
`endif

  assign s_cyc_o = req.cyc;
  assign s_stb_o = raw_stb & ~to_fire;
  assign s_we_o  = req.we;
  assign s_adr_o = req.adr;
  assign s_dat_o = req.dat;

  assign ack_any = (s_ack_i & raw_stb) | to_fire;
  assign rdata   = to_fire ? ERR_DATA : s_dat_i;

  assign m0_ack_o = own0 & ack_any;
  assign m1_ack_o = own1 & ack_any;
  assign m0_dat_o = own0 ? rdata : '0;
  assign m1_dat_o = own1 ? rdata : '0;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Randomised + directed bench for wb_arbiter_2m against a cycle-level
// reference model of the arbitration and watchdog rules.
module tb_wb_arbiter_2m;

  localparam int TO = 16;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = '0;
  logic [15:0] m0_dat = '0;
  logic [15:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = '0;
  logic [15:0] m1_dat = '0;
  logic [15:0] m1_dat_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o;
  logic [15:0] s_dat_o;
  logic [15:0] s_dat = '0;
  logic        s_ack = 1'b0;
  logic        timeout_o;
  logic [7:0]  to_count_o;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int own;
  int last;
  int waitn;
  int tocnt;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.TIMEOUT(TO), .ERR_DATA(16'hDEAD)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack),
    .timeout_o(timeout_o), .to_count_o(to_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own   = -1;
    last  = 1;
    waitn = 0;
    tocnt = 0;
  endtask

  // Check outputs for the current inputs, then advance one clock.
  task automatic cycle();
    logic        cy[2], sb[2], we[2];
    logic [31:0] ad[2];
    logic [15:0] dt[2];
    logic        ec, es, ewe, fire, oack;
    logic [31:0] ea;
    logic [15:0] ed, rd;
    int          nxt;
    #1;
    cy[0] = m0_cyc; sb[0] = m0_stb; we[0] = m0_we;
    ad[0] = m0_adr; dt[0] = m0_dat;
    cy[1] = m1_cyc; sb[1] = m1_stb; we[1] = m1_we;
    ad[1] = m1_adr; dt[1] = m1_dat;
    ec = 0; es = 0; ewe = 0; ea = '0; ed = '0;
    if (own >= 0) begin
      ec  = cy[own];
      es  = cy[own] & sb[own];
      ewe = we[own];
      ea  = ad[own];
      ed  = dt[own];
    end
    fire = TO_EN && es && !s_ack && (waitn == TO);
    oack = (es && s_ack) || fire;
    rd   = fire ? 16'hDEAD : s_dat;
    chk("s_cyc", s_cyc_o, ec);
    chk("s_stb", s_stb_o, es && !fire);
    chk("s_we", s_we_o, ewe);
    chk("s_adr", s_adr_o, ea);
    chk("s_dat", s_dat_o, ed);
    chk("m0_ack", m0_ack_o, (own == 0) && oack);
    chk("m1_ack", m1_ack_o, (own == 1) && oack);
    chk("m0_dat", m0_dat_o, (own == 0) ? rd : 16'h0);
    chk("m1_dat", m1_dat_o, (own == 1) ? rd : 16'h0);
    chk("timeout", timeout_o, fire);
    chk("to_count", to_count_o, tocnt);
    waitn = (es && !s_ack && !fire) ? waitn + 1 : 0;
    if (fire && tocnt < 255) tocnt++;
    nxt = own;
    if (own < 0) begin
      if (cy[0] && cy[1]) nxt = (last == 0) ? 1 : 0;
      else if (cy[0])     nxt = 0;
      else if (cy[1])     nxt = 1;
    end else if (!cy[own]) begin
      nxt = cy[1 - own] ? 1 - own : -1;
    end
    if (nxt >= 0 && nxt != own) last = nxt;
    own = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_m0_ack", m0_ack_o, 0);
    chk("rst_m1_ack", m1_ack_o, 0);
    chk("rst_to_count", to_count_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    bit hang;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_cyc", s_cyc_o, 0);
    chk("reset_s_stb", s_stb_o, 0);
    chk("reset_s_adr", s_adr_o, 0);
    chk("reset_m0_ack", m0_ack_o, 0);
    chk("reset_m1_dat", m1_dat_o, 0);
    chk("reset_timeout", timeout_o, 0);
    chk("reset_to_count", to_count_o, 0);
    reset_n = 1'b1;

    // single write from master 0
    m0_cyc = 1; m0_stb = 1; m0_we = 1;
    m0_adr = 32'hdeadbeef; m0_dat = 16'hfeed;
    cycle();
    #1;
    chk("t1_adr", s_adr_o, 32'hdeadbeef);
    chk("t1_dat", s_dat_o, 16'hfeed);
    chk("t1_we", s_we_o, 1);
    cycle();
    s_ack = 1;
    #1;
    chk("t1_ack0", m0_ack_o, 1);
    chk("t1_ack1", m1_ack_o, 0);
    cycle();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    chk("t1_ack_once", m0_ack_o, 0);
    cycle();

    // hung slave on a master 1 read
    m1_cyc = 1; m1_stb = 1; m1_we = 0;
    m1_adr = 32'h0000_1000; s_dat = 16'h5555;
    cycle();
`ifdef WB_ARB_TIMEOUT_EN
    n = 1;
    while (!m1_ack_o && n < 40) begin
      cycle();
      n++;
    end
    chk("t4_latency", n, 17);
    chk("t4_dat", m1_dat_o, 16'hDEAD);
    chk("t4_pulse", timeout_o, 1);
    chk("t4_stb_forced", s_stb_o, 0);
    cycle();
    chk("t4_to_count", to_count_o, 1);
    chk("t4_pulse_end", timeout_o, 0);
    repeat (15) cycle();
    s_ack = 1;
    #1;
    chk("t4b_no_pulse", timeout_o, 0);
    chk("t4b_ack", m1_ack_o, 1);
    chk("t4b_dat", m1_dat_o, 16'h5555);
    cycle();
    chk("t4b_to_count", to_count_o, 1);
`else
    repeat (20) cycle();
    chk("t4_hung_ack", m1_ack_o, 0);
    chk("t4_hung_stb", s_stb_o, 1);
    chk("t4_no_pulse", timeout_o, 0);
    chk("t4_no_count", to_count_o, 0);
`endif
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    cycle();

    // reset in the middle of a master 1 tenure
    m1_cyc = 1; m1_stb = 1;
    cycle();
    s_ack = 1;
    #1;
    chk("t5_pre_ack", m1_ack_o, 1);
    do_reset();
    s_ack = 0;

    // simultaneous requests after reset: master 0 first
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_0a00;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h0000_0b00;
    cycle();
    #1;
    chk("t2_first", s_adr_o, 32'h0000_0a00);
    s_ack = 1;
    cycle();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    cycle();
    chk("t2_own1_cyc", s_cyc_o, 1);
    chk("t2_own1_adr", s_adr_o, 32'h0000_0b00);
    s_dat = 16'h1234; s_ack = 1;
    #1;
    chk("t2_rdata", m1_dat_o, 16'h1234);
    chk("t2_ack", m1_ack_o, 1);
    chk("t2_other_dat", m0_dat_o, 0);
    cycle();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    cycle();

    // continuous contention: tenures alternate
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    n = 0;
    while (!s_cyc_o && n < 5) begin
      cycle();
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_grant", s_adr_o == 32'h0000_0b00, k % 2);
      if (s_adr_o == 32'h0000_0b00) begin
        m1_cyc = 0; m1_stb = 0;
      end else begin
        m0_cyc = 0; m0_stb = 0;
      end
      cycle();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    cycle();

    // randomised traffic, hung-slave windows and occasional resets
    hang = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) hang = !hang;
      if (m0_cyc) m0_cyc = ($urandom_range(0, 7) != 0);
      else        m0_cyc = ($urandom_range(0, 2) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(0, 7) != 0);
      else        m1_cyc = ($urandom_range(0, 2) == 0);
      m0_stb = ($urandom_range(0, 3) != 0);
      m1_stb = ($urandom_range(0, 3) != 0);
      m0_we  = $urandom_range(0, 1);
      m1_we  = $urandom_range(0, 1);
      m0_adr = $urandom;
      m1_adr = $urandom;
      m0_dat = 16'($urandom);
      m1_dat = 16'($urandom);
      s_dat  = 16'($urandom);
      s_ack  = hang ? 1'b0 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
